// File: rtl/cand_sampler.sv
// rtl/cand_sampler.sv - pseudo-random candidate sampler feeding a constraint checker
module cand_sampler #(
  parameter int CAND_W = 307,
  parameter int NW     = (CAND_W + 31) / 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [15:0]       max_tries,
  input  logic [7:0]        num_samples,
  output logic [CAND_W-1:0] cand,
  input  logic              chk_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CAND_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       tries
);

  localparam int             FCW       = $clog2(NW + 1);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(NW - 1);
  localparam logic [31:0]    LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, FILL, CHECK, EMIT, FIN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [31:0]    lfsr;
  logic [FCW-1:0] fill_cnt;
  logic [7:0]     acc_cnt;
  logic [7:0]     num_r;
  logic [15:0]    max_r;
  logic [15:0]    tries_inc;
  logic [7:0]     acc_inc;
  logic           hit_limit;

  // tries saturates rather than wrapping so a long unlimited run stays readable
  assign tries_inc = (tries == 16'hFFFF) ? tries : tries + 16'd1;
  assign acc_inc   = acc_cnt + 8'd1;
  assign hit_limit = (max_r != 16'd0) && (tries_inc == max_r);

  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_samples == 8'd0) ? FIN : FILL;
      FILL:  if (fill_cnt == FILL_LAST) state_nxt = CHECK;
      CHECK: begin
        if (chk_ok)         state_nxt = EMIT;
        else if (hit_limit) state_nxt = FIN;
        else                state_nxt = FILL;
      end
      EMIT:  if (out_ready) state_nxt = (acc_inc == num_r) ? FIN : FILL;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: LFSR, candidate assembly, counters and captured run parameters
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= 32'h0000_0001;
      cand     <= '0;
      out_data <= '0;
      fill_cnt <= '0;
      acc_cnt  <= 8'd0;
      num_r    <= 8'd0;
      max_r    <= 16'd0;
      tries    <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // an all-zero seed would lock the LFSR, so it is nudged to 1
          lfsr     <= (seed == 32'd0) ? 32'h0000_0001 : seed;
          fill_cnt <= '0;
          acc_cnt  <= 8'd0;
          tries    <= 16'd0;
          timeout  <= 1'b0;
          num_r    <= num_samples;
          max_r    <= max_tries;
        end
        FILL: begin
          cand     <= {lfsr, cand[CAND_W-1:32]};
          lfsr     <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'd0);
          fill_cnt <= (fill_cnt == FILL_LAST) ? '0 : fill_cnt + 1'b1;
        end
        CHECK: begin
          tries <= tries_inc;
          if (chk_ok)         out_data <= cand;
          else if (hit_limit) timeout  <= 1'b1;
        end
        EMIT: if (out_ready) acc_cnt <= acc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cand_sampler.sv
// tb/tb_cand_sampler.sv - scoreboard bench for cand_sampler
module tb_cand_sampler;
  localparam int CAND_W = 307;
  localparam int NW     = 10;

  typedef logic [CAND_W-1:0] w_t;

  typedef struct {
    logic [31:0] seed;
    logic [15:0] max_t;
    logic [7:0]  num;
    logic [1:0]  mode;
    bit          rnd;
    bit          glitch;
    int          exp_tries;
    int          exp_to;
    int          exp_cyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic [15:0] max_tries;
  logic [7:0]  num_samples;
  w_t          cand;
  logic        chk_ok;
  logic        out_valid;
  logic        out_ready;
  w_t          out_data;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] tries;

  int   n_vec = 0;
  int   n_bad = 0;
  int   gcyc  = 0;
  logic [1:0] mode = 2'd0;
  bit   rand_ready = 1'b0;
  logic ready_hold = 1'b1;
  bit   gap_chk = 1'b0;
  int   last_hs = -1;
  int   hs_count = 0;
  bit   stall_prev = 1'b0;
  w_t   stall_data;
  w_t   exp_q[$];
  vec_t vecs[8];

  cand_sampler #(.CAND_W(CAND_W), .NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .max_tries(max_tries),
    .num_samples(num_samples), .cand(cand), .chk_ok(chk_ok), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done),
    .timeout(timeout), .tries(tries)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic pred(input w_t c);
    return c[0] ^ c[77] ^ c[306];
  endfunction

  assign chk_ok = (mode == 2'd0) || ((mode == 2'd2) && pred(cand));

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  task automatic check(input string name, input w_t act, input w_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference model: pushes expected out_data per accepted candidate
  task automatic model_run(input logic [31:0] sd, input logic [15:0] mt, input logic [7:0] ns,
                           input logic [1:0] md, output int e_tries, output int e_to, output int e_cyc);
    logic [31:0] l;
    w_t          c;
    int          acc;
    logic        ok;
    l = (sd == 32'd0) ? 32'd1 : sd;
    c = '0;
    acc = 0;
    e_tries = 0;
    e_to = 0;
    e_cyc = 0;
    if (ns != 8'd0) begin
      forever begin
        for (int i = 0; i < NW; i++) begin
          c = {l, c[CAND_W-1:32]};
          l = step(l);
        end
        e_tries = (e_tries == 65535) ? e_tries : e_tries + 1;
        e_cyc += NW + 1;
        ok = (md == 2'd0) || ((md == 2'd2) && pred(c));
        if (ok) begin
          exp_q.push_back(c);
          e_cyc++;
          acc++;
          if (acc == int'(ns)) break;
        end else if (mt != 16'd0 && e_tries == int'(mt)) begin
          e_to = 1;
          break;
        end
      end
    end
    e_cyc++;
  endtask

  // Monitor: drives out_ready, scoreboards handshakes, checks hold under backpressure
  always @(negedge clk) begin
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
    if (!rst) begin
      if (stall_prev && out_valid) check("stall_hold", out_data, stall_data);
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_emit: got %0h expected no output", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        if (gap_chk && last_hs >= 0) check("hs_gap", w_t'(gcyc - last_hs), w_t'(12));
        last_hs = gcyc;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic run_vec(input vec_t v);
    int e_tries, e_to, e_cyc, cyc, first_valid;
    model_run(v.seed, v.max_t, v.num, v.mode, e_tries, e_to, e_cyc);
    if (v.exp_tries >= 0) e_tries = v.exp_tries;
    if (v.exp_to >= 0)    e_to    = v.exp_to;
    if (v.exp_cyc >= 0)   e_cyc   = v.exp_cyc;
    seed = v.seed;
    max_tries = v.max_t;
    num_samples = v.num;
    mode = v.mode;
    ready_hold = 1'b1;
    rand_ready = v.rnd;
    gap_chk = (v.mode == 2'd0) && !v.rnd;
    last_hs = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    first_valid = 0;
    // scramble the inputs after capture; the run must not notice
    seed = 32'h5555_AAAA;
    max_tries = 16'd1;
    num_samples = 8'd9;
    while (!done && cyc < 5000) begin
      if (out_valid && first_valid == 0) first_valid = cyc;
      start = v.glitch && (cyc == 5);
      tick;
      cyc++;
    end
    start = 1'b0;
    check("done_seen", w_t'(done), w_t'(1));
    if (!v.rnd) check("done_cycle", w_t'(cyc), w_t'(e_cyc));
    if (gap_chk && v.num != 8'd0) check("first_valid", w_t'(first_valid), w_t'(12));
    check("tries", w_t'(tries), w_t'(e_tries));
    check("timeout", w_t'(timeout), w_t'(e_to));
    check("queue_drained", w_t'(exp_q.size()), w_t'(0));
    exp_q.delete();
    tick;
    check("done_pulse", w_t'(done), w_t'(0));
    check("idle_busy", w_t'(busy), w_t'(0));
    check("idle_tries", w_t'(tries), w_t'(e_tries));
    check("idle_timeout", w_t'(timeout), w_t'(e_to));
    rand_ready = 1'b0;
    gap_chk = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
    check(name, w_t'(out_valid), w_t'(1));
  endtask

  initial begin
    int e_tries, e_to, e_cyc, hs0;
    w_t held;

    //        seed          max     num    mode  rnd glt tries to  cyc
    vecs[0] = '{32'h0000_0001, 16'd0, 8'd3,   2'd0, 0, 0, 3,  0,  37};
    vecs[1] = '{32'h0000_ACE1, 16'd5, 8'd2,   2'd1, 0, 0, 5,  1,  56};
    vecs[2] = '{32'h1234_5678, 16'd0, 8'd0,   2'd0, 0, 0, 0,  0,  1};
    vecs[3] = '{32'hDEAD_BEEF, 16'd0, 8'd4,   2'd2, 1, 0, -1, -1, -1};
    vecs[4] = '{32'hCAFE_F00D, 16'd4, 8'd2,   2'd2, 0, 0, -1, -1, -1};
    vecs[5] = '{32'h0000_0000, 16'd0, 8'd3,   2'd2, 0, 0, -1, -1, -1};
    vecs[6] = '{32'h0000_0001, 16'd0, 8'd3,   2'd2, 0, 0, -1, -1, -1};
    vecs[7] = '{32'h0000_0001, 16'd0, 8'd2,   2'd0, 0, 1, 2,  0,  25};

    rst = 1'b1;
    start = 1'b0;
    seed = 32'd0;
    max_tries = 16'd0;
    num_samples = 8'd0;
    repeat (3) tick;
    check("rst_valid", w_t'(out_valid), w_t'(0));
    check("rst_busy", w_t'(busy), w_t'(0));
    check("rst_done", w_t'(done), w_t'(0));
    check("rst_timeout", w_t'(timeout), w_t'(0));
    check("rst_tries", w_t'(tries), w_t'(0));
    check("rst_cand", cand, '0);
    check("rst_out_data", out_data, '0);
    rst = 1'b0;
    tick;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset held for two cycles while a candidate is waiting in EMIT
    mode = 2'd0;
    ready_hold = 1'b0;
    seed = 32'h0BAD_F00D;
    max_tries = 16'd0;
    num_samples = 8'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid("emit_before_rst");
    rst = 1'b1;
    start = 1'b1;
    tick;
    check("rst_emit_valid", w_t'(out_valid), w_t'(0));
    check("rst_emit_busy", w_t'(busy), w_t'(0));
    check("rst_emit_tries", w_t'(tries), w_t'(0));
    tick;
    rst = 1'b0;
    start = 1'b0;
    check("rst_emit_out_data", out_data, '0);
    tick;
    check("rst_emit_idle", w_t'(busy), w_t'(0));

    // backpressure: seven stalled cycles, then exactly one handshake
    model_run(32'h0000_7777, 16'd0, 8'd1, 2'd0, e_tries, e_to, e_cyc);
    seed = 32'h0000_7777;
    num_samples = 8'd1;
    ready_hold = 1'b0;
    hs0 = hs_count;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid("bp_valid");
    held = out_data;
    repeat (7) tick;
    check("bp_valid_held", w_t'(out_valid), w_t'(1));
    check("bp_data_held", out_data, held);
    check("bp_no_hs", w_t'(hs_count - hs0), w_t'(0));
    ready_hold = 1'b1;
    for (int n = 0; n < 20 && !done; n++) tick;
    check("bp_done", w_t'(done), w_t'(1));
    check("bp_one_hs", w_t'(hs_count - hs0), w_t'(1));
    check("bp_tries", w_t'(tries), w_t'(1));
    check("bp_queue", w_t'(exp_q.size()), w_t'(0));
    repeat (2) tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
